// File: rtl/playfield_renderer.sv
// rtl/playfield_renderer.sv - parametrised playfield colour generator
//
// Ports:
//   raw_clk     clock, all logic on the rising edge
//   reset       asynchronous active-low reset
//   pixel_en    one-cycle pixel strobe; pixel-domain state only moves when high
//   in_image    high during visible pixels, sampled on pixel_en
//   wr_en       register write strobe
//   wr_addr     register select (0..3 pf bytes, 4 fg, 5 bg, 6 border, 7 ctrl)
//   wr_data     register write data
//   color       registered colour index for the current pixel
//   line_done   one-cycle pulse after the last right-half pixel
//   active_ctrl ctrl bits latched for the line in progress
module playfield_renderer #(
  parameter int PF_BITS        = 22,
  parameter int PIXELS_PER_BIT = 16,
  parameter int COLOR_WIDTH    = 7
) (
  input  logic                   raw_clk,
  input  logic                   reset,
  input  logic                   pixel_en,
  input  logic                   in_image,
  input  logic                   wr_en,
  input  logic [2:0]             wr_addr,
  input  logic [7:0]             wr_data,
  output logic [COLOR_WIDTH-1:0] color,
  output logic                   line_done,
  output logic [1:0]             active_ctrl
);

  localparam int BIT_W = (PF_BITS > 1) ? $clog2(PF_BITS) : 1;
  localparam int SUB_W = (PIXELS_PER_BIT > 1) ? $clog2(PIXELS_PER_BIT) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PF_BITS - 1);
  localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(PIXELS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2,
    S_TAIL  = 2'd3
  } state_t;

  // Shadow registers (CPU side)
  logic [PF_BITS-1:0]     pf_sh_q, pf_sh_d;
  logic [COLOR_WIDTH-1:0] fg_sh_q, fg_sh_d;
  logic [COLOR_WIDTH-1:0] bg_sh_q, bg_sh_d;
  logic [COLOR_WIDTH-1:0] bd_sh_q, bd_sh_d;
  logic [1:0]             ctrl_sh_q, ctrl_sh_d;

  // Active registers (frozen for the line in progress)
  logic [PF_BITS-1:0]     pf_act_q, pf_act_d;
  logic [COLOR_WIDTH-1:0] fg_act_q, fg_act_d;
  logic [COLOR_WIDTH-1:0] bg_act_q, bg_act_d;
  logic [COLOR_WIDTH-1:0] bd_act_q, bd_act_d;
  logic [1:0]             ctrl_act_q, ctrl_act_d;

  // Pixel-domain state
  state_t                 state_q, state_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [SUB_W-1:0]       sub_q, sub_d;
  logic [COLOR_WIDTH-1:0] color_q, color_d;
  logic                   line_done_q, line_done_d;

  // Working values for the strobe being processed
  logic                   line_start;
  state_t                 cur_state;
  logic [BIT_W-1:0]       cur_bit;
  logic [SUB_W-1:0]       cur_sub;
  logic                   bit_last;
  logic [PF_BITS-1:0]     pf_use;
  logic [COLOR_WIDTH-1:0] fg_use;
  logic [COLOR_WIDTH-1:0] bg_use;
  logic [1:0]             ctrl_use;
  logic [COLOR_WIDTH-1:0] pf_color;

  // Shadow register writes
  always_comb begin
    pf_sh_d   = pf_sh_q;
    fg_sh_d   = fg_sh_q;
    bg_sh_d   = bg_sh_q;
    bd_sh_d   = bd_sh_q;
    ctrl_sh_d = ctrl_sh_q;
    if (wr_en) begin
      case (wr_addr)
        3'd4:    fg_sh_d   = COLOR_WIDTH'(wr_data);
        3'd5:    bg_sh_d   = COLOR_WIDTH'(wr_data);
        3'd6:    bd_sh_d   = COLOR_WIDTH'(wr_data);
        3'd7:    ctrl_sh_d = wr_data[1:0];
        default: begin
          // Byte k covers pf bits 8k..8k+7; bits beyond PF_BITS simply don't exist.
          for (int i = 0; i < PF_BITS; i++) begin
            if (wr_addr == 3'(i / 8)) begin
              pf_sh_d[i] = wr_data[3'(i % 8)];
            end
          end
        end
      endcase
    end
  end

  // Pixel state machine and colour selection
  always_comb begin
    line_start = pixel_en && in_image && (state_q == S_IDLE);

    // Pixel 0 is rendered on the line-start strobe itself, while the active
    // copy is still being loaded, so that strobe reads the shadow values.
    pf_use    = line_start ? pf_sh_q   : pf_act_q;
    fg_use    = line_start ? fg_sh_q   : fg_act_q;
    bg_use    = line_start ? bg_sh_q   : bg_act_q;
    ctrl_use  = line_start ? ctrl_sh_q : ctrl_act_q;
    cur_state = line_start ? S_LEFT    : state_q;
    cur_bit   = line_start ? LAST_BIT  : bit_q;
    cur_sub   = line_start ? '0        : sub_q;

    bit_last = (cur_sub == LAST_SUB);
    pf_color = (ctrl_use[1] && pf_use[cur_bit]) ? fg_use : bg_use;

    pf_act_d    = line_start ? pf_sh_q   : pf_act_q;
    fg_act_d    = line_start ? fg_sh_q   : fg_act_q;
    bg_act_d    = line_start ? bg_sh_q   : bg_act_q;
    bd_act_d    = line_start ? bd_sh_q   : bd_act_q;
    ctrl_act_d  = line_start ? ctrl_sh_q : ctrl_act_q;

    state_d     = state_q;
    bit_d       = bit_q;
    sub_d       = sub_q;
    color_d     = color_q;
    line_done_d = 1'b0;

    if (pixel_en) begin
      if (!in_image) begin
        state_d = S_IDLE;
        color_d = '0;
      end else begin
        case (cur_state)
          S_LEFT: begin
            state_d = S_LEFT;
            color_d = pf_color;
            sub_d   = bit_last ? '0 : cur_sub + 1'b1;
            bit_d   = cur_bit;
            if (bit_last) begin
              if (cur_bit == '0) begin
                state_d = S_RIGHT;
                bit_d   = ctrl_use[0] ? '0 : LAST_BIT;
              end else begin
                bit_d = cur_bit - 1'b1;
              end
            end
          end
          S_RIGHT: begin
            color_d = pf_color;
            sub_d   = bit_last ? '0 : cur_sub + 1'b1;
            if (bit_last) begin
              if (ctrl_use[0] ? (cur_bit == LAST_BIT) : (cur_bit == '0)) begin
                state_d     = S_TAIL;
                line_done_d = 1'b1;
              end else begin
                bit_d = ctrl_use[0] ? cur_bit + 1'b1 : cur_bit - 1'b1;
              end
            end
          end
          S_TAIL:  color_d = bd_act_q;
          default: color_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      pf_sh_q     <= '0;
      fg_sh_q     <= '0;
      bg_sh_q     <= '0;
      bd_sh_q     <= '0;
      ctrl_sh_q   <= '0;
      pf_act_q    <= '0;
      fg_act_q    <= '0;
      bg_act_q    <= '0;
      bd_act_q    <= '0;
      ctrl_act_q  <= '0;
      state_q     <= S_IDLE;
      bit_q       <= '0;
      sub_q       <= '0;
      color_q     <= '0;
      line_done_q <= 1'b0;
    end else begin
      pf_sh_q     <= pf_sh_d;
      fg_sh_q     <= fg_sh_d;
      bg_sh_q     <= bg_sh_d;
      bd_sh_q     <= bd_sh_d;
      ctrl_sh_q   <= ctrl_sh_d;
      pf_act_q    <= pf_act_d;
      fg_act_q    <= fg_act_d;
      bg_act_q    <= bg_act_d;
      bd_act_q    <= bd_act_d;
      ctrl_act_q  <= ctrl_act_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      sub_q       <= sub_d;
      color_q     <= color_d;
      line_done_q <= line_done_d;
    end
  end

  assign color       = color_q;
  assign line_done   = line_done_q;
  assign active_ctrl = ctrl_act_q;

endmodule

// File: tb/tb_playfield_renderer.sv
// tb/tb_playfield_renderer.sv - scoreboard bench for playfield_renderer
module tb_playfield_renderer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       pixel_en;
  logic       in_image;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] color_a, color_b;
  logic       line_done_a, line_done_b;
  logic [1:0] actl_a, actl_b;

  playfield_renderer u_a (
    .raw_clk(clk), .reset(reset), .pixel_en(pixel_en), .in_image(in_image),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .color(color_a), .line_done(line_done_a), .active_ctrl(actl_a)
  );

  playfield_renderer #(.PF_BITS(8), .PIXELS_PER_BIT(4), .COLOR_WIDTH(7)) u_b (
    .raw_clk(clk), .reset(reset), .pixel_en(pixel_en), .in_image(in_image),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .color(color_b), .line_done(line_done_b), .active_ctrl(actl_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [6:0] col_a;
    logic       done_a;
    logic [1:0] ctl_a;
    logic [6:0] col_b;
    logic       done_b;
    logic [1:0] ctl_b;
  } exp_t;

  exp_t exp_q[$];

  // Register model
  logic [31:0] sh_pf;
  logic [6:0]  sh_fg, sh_bg, sh_bd;
  logic [1:0]  sh_ctl;

  // Per-instance line model: index 0 = defaults, 1 = 8 bits x 4 pixels
  int          nb [2] = '{22, 8};
  int          ppb[2] = '{16, 4};
  bit          m_in [2];
  int          m_pos[2];
  logic [31:0] m_pf [2];
  logic [6:0]  m_fg [2], m_bg[2], m_bd[2];
  logic [1:0]  m_ctl[2];

  logic [6:0]  last_a, last_b;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Colour of visible pixel p counted from the line start
  function automatic logic [6:0] ref_color(input int p, input int bits, input int pix,
                                           input logic [31:0] pf, input logic [6:0] fg,
                                           input logic [6:0] bg, input logic [6:0] bd,
                                           input logic [1:0] ctl);
    int half;
    int b;
    half = bits * pix;
    if (p >= 2 * half) return bd;
    if (p < half) begin
      b = bits - 1 - p / pix;
    end else begin
      b = (p - half) / pix;
      if (!ctl[0]) b = bits - 1 - b;
    end
    return (ctl[1] && pf[b]) ? fg : bg;
  endfunction

  task automatic model_reset();
    sh_pf = '0; sh_fg = '0; sh_bg = '0; sh_bd = '0; sh_ctl = '0;
    for (int k = 0; k < 2; k++) begin
      m_in[k] = 0; m_pos[k] = 0; m_pf[k] = '0;
      m_fg[k] = '0; m_bg[k] = '0; m_bd[k] = '0; m_ctl[k] = '0;
    end
  endtask

  task automatic model_strobe(input bit img, input int k, output logic [6:0] col,
                              output logic done, output logic [1:0] ctl);
    if (!img) begin
      m_in[k] = 0;
      col  = '0;
      done = 1'b0;
    end else begin
      if (!m_in[k]) begin
        m_in[k] = 1; m_pos[k] = 0;
        m_pf[k] = sh_pf; m_fg[k] = sh_fg; m_bg[k] = sh_bg; m_bd[k] = sh_bd; m_ctl[k] = sh_ctl;
      end
      col  = ref_color(m_pos[k], nb[k], ppb[k], m_pf[k], m_fg[k], m_bg[k], m_bd[k], m_ctl[k]);
      done = (m_pos[k] == 2 * nb[k] * ppb[k] - 1);
      if (m_pos[k] < 100000) m_pos[k]++;
    end
    ctl = m_ctl[k];
  endtask

  task automatic tick(input bit pe, input bit img, input bit we,
                      input logic [2:0] a, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    pixel_en = pe; in_image = img; wr_en = we; wr_addr = a; wr_data = d;
    if (pe) begin
      model_strobe(img, 0, e.col_a, e.done_a, e.ctl_a);
      model_strobe(img, 1, e.col_b, e.done_b, e.ctl_b);
      exp_q.push_back(e);
    end
    if (we) begin
      case (a)
        3'd4:    sh_fg  = d[6:0];
        3'd5:    sh_bg  = d[6:0];
        3'd6:    sh_bd  = d[6:0];
        3'd7:    sh_ctl = d[1:0];
        default: sh_pf[8 * a +: 8] = d;
      endcase
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    tick(0, 0, 1, a, d);
  endtask

  task automatic run_line(input int npix, input int wr_pix, input logic [2:0] wa,
                          input logic [7:0] wd, input bit rnd);
    int p;
    bit pe, we;
    logic [2:0] a;
    logic [7:0] d;
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 3'd0, 8'd0);
    p = 0;
    while (p < npix) begin
      pe = ($urandom_range(0, 3) != 0);
      we = 0; a = '0; d = '0;
      if (pe && p == wr_pix) begin
        we = 1; a = wa; d = wd;
      end else if (rnd && $urandom_range(0, 63) == 0) begin
        we = 1; a = 3'($urandom_range(0, 7)); d = 8'($urandom);
      end
      tick(pe, 1, we, a, d);
      if (pe) p++;
    end
    tick(1, 0, 0, 3'd0, 8'd0);
  endtask

  // Monitor: pops one expectation per strobe, checks hold behaviour otherwise
  initial begin : monitor
    logic pe;
    exp_t e;
    last_a = '0;
    last_b = '0;
    forever begin
      @(posedge clk);
      pe = pixel_en;
      #1;
      if (!reset) begin
        last_a = '0;
        last_b = '0;
      end else if (pe) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("color_a", color_a, e.col_a);
          check("line_done_a", line_done_a, e.done_a);
          check("active_ctrl_a", actl_a, e.ctl_a);
          check("color_b", color_b, e.col_b);
          check("line_done_b", line_done_b, e.done_b);
          check("active_ctrl_b", actl_b, e.ctl_b);
          last_a = e.col_a;
          last_b = e.col_b;
        end
      end else begin
        check("hold_a", color_a, last_a);
        check("hold_b", color_b, last_b);
        check("done_idle_a", line_done_a, 1'b0);
        check("done_idle_b", line_done_b, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b0; pixel_en = 1'b0; in_image = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_color_a", color_a, 7'h00);
    check("rst_done_a", line_done_a, 1'b0);
    check("rst_ctrl_a", actl_a, 2'b00);
    check("rst_color_b", color_b, 7'h00);
    check("rst_done_b", line_done_b, 1'b0);
    check("rst_ctrl_b", actl_b, 2'b00);
    reset = 1'b1;

    // Defaults: everything renders as colour 0
    run_line(800, -1, 3'd0, 8'd0, 0);

    // Single bits at both ends, mirrored right half
    wr(3'd0, 8'h01); wr(3'd1, 8'h00); wr(3'd2, 8'h20); wr(3'd3, 8'h00);
    wr(3'd4, 8'h0c); wr(3'd5, 8'h4c); wr(3'd6, 8'h55); wr(3'd7, 8'h03);
    run_line(800, -1, 3'd0, 8'd0, 0);

    // Repeat mode
    wr(3'd7, 8'h02);
    run_line(800, -1, 3'd0, 8'd0, 0);

    // Mid-line write, then write on the line-start strobe
    wr(3'd7, 8'h03);
    run_line(800, 100, 3'd4, 8'h10, 0);
    run_line(800, -1, 3'd0, 8'd0, 0);
    run_line(800, 0, 3'd4, 8'h22, 0);
    run_line(800, -1, 3'd0, 8'd0, 0);

    // Short line, then a full one
    run_line(300, -1, 3'd0, 8'd0, 0);
    run_line(800, -1, 3'd0, 8'd0, 0);

    // Randomised registers, line lengths and stray writes
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 8; a++) wr(3'(a), 8'($urandom));
      run_line($urandom_range(40, 900), -1, 3'd0, 8'd0, 1);
    end

    // Asynchronous reset in the left half
    wr(3'd0, 8'hff); wr(3'd2, 8'h3f); wr(3'd4, 8'h33); wr(3'd7, 8'h03);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 3'd0, 8'd0);
    for (int i = 0; i < 100; i++) tick(1, 1, 0, 3'd0, 8'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_color_a", color_a, 7'h00);
    check("async_ctrl_a", actl_a, 2'b00);
    check("async_color_b", color_b, 7'h00);
    check("async_ctrl_b", actl_b, 2'b00);
    model_reset();
    pixel_en = 1'b0; in_image = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wr(3'd0, 8'h81); wr(3'd2, 8'h20); wr(3'd4, 8'h0c); wr(3'd5, 8'h4c);
    wr(3'd6, 8'h7e); wr(3'd7, 8'h03);
    run_line(800, -1, 3'd0, 8'd0, 0);
    wr(3'd7, 8'h02);
    run_line(70, -1, 3'd0, 8'd0, 0);

    for (int i = 0; i < 3; i++) tick(0, 0, 0, 3'd0, 8'd0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
